// File: rtl/hit_judge.sv
// hit_judge: single-lane timing judge turning button presses against note windows into hit/miss/perfect pulses
module hit_judge #(
  parameter int HALF_WIN   = 8,
  parameter int PERF_HALF  = 2,
  parameter int STRAY_MISS = 1,
  parameter int CNT_W      = 5
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_En,
  input  logic i_Tick,
  input  logic i_Note,
  input  logic i_Btn,
  output logic o_Hit,
  output logic o_Miss,
  output logic o_Perfect,
  output logic o_Open
);
  typedef enum logic {IDLE, OPEN} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * HALF_WIN);
  localparam logic [CNT_W-1:0] P_LO = CNT_W'(HALF_WIN - PERF_HALF);
  localparam logic [CNT_W-1:0] P_HI = CNT_W'(HALF_WIN + PERF_HALF);
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0] sync_q, sync_d;
  logic hit_q, hit_d, miss_q, miss_d, perf_q, perf_d;
  logic press;
  assign press = sync_q[1] & ~sync_q[2];
  assign o_Hit = hit_q;
  assign o_Miss = miss_q;
  assign o_Perfect = perf_q;
  assign o_Open = state_q == OPEN;
  // The synchronizer runs regardless of i_En so a press edge seen while disabled is simply dropped.
  always_comb begin
    sync_d = {sync_q[1:0], i_Btn};
    state_d = state_q;
    cnt_d = cnt_q;
    hit_d = 1'b0;
    miss_d = 1'b0;
    perf_d = 1'b0;
    if (!i_En) begin
      state_d = IDLE;
      cnt_d = '0;
    end else if (state_q == IDLE) begin
      miss_d = press && (STRAY_MISS != 0);
      if (i_Note) begin
        state_d = OPEN;
        cnt_d = '0;
      end
    end else if (press) begin
      hit_d = 1'b1;
      perf_d = cnt_q >= P_LO && cnt_q <= P_HI;
      state_d = i_Note ? OPEN : IDLE;
      cnt_d = '0;
    end else if (i_Note) begin
      miss_d = 1'b1;
      cnt_d = '0;
    end else if (i_Tick && cnt_q == LAST) begin
      miss_d = 1'b1;
      state_d = IDLE;
      cnt_d = '0;
    end else if (i_Tick) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      sync_q <= '0;
      hit_q <= 1'b0;
      miss_q <= 1'b0;
      perf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      sync_q <= sync_d;
      hit_q <= hit_d;
      miss_q <= miss_d;
      perf_q <= perf_d;
    end
  end
endmodule

// File: tb/tb_hit_judge.sv
// tb_hit_judge: directed checks of hit_judge windows, perfect band, stray, expiry, reset and enable handling
module tb_hit_judge;
  logic clk = 1'b0, rst = 1'b1, en = 1'b1, tick = 1'b0, note = 1'b0, btn = 1'b0;
  logic hit, miss, perf, open, hit0, miss0, perf0, open0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  hit_judge dut (.i_Clk(clk), .i_Rst(rst), .i_En(en), .i_Tick(tick), .i_Note(note), .i_Btn(btn),
                 .o_Hit(hit), .o_Miss(miss), .o_Perfect(perf), .o_Open(open));
  hit_judge #(.STRAY_MISS(0)) dut0 (.i_Clk(clk), .i_Rst(rst), .i_En(en), .i_Tick(tick), .i_Note(note),
                 .i_Btn(btn), .o_Hit(hit0), .o_Miss(miss0), .o_Perfect(perf0), .o_Open(open0));
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic clk1();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk1();
  endtask
  task automatic pulse_note();
    note = 1'b1;
    clk1();
    note = 1'b0;
  endtask
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1;
      clk1();
      tick = 1'b0;
    end
  endtask
  task automatic outs(input string tag, input int h, input int m, input int p, input int o);
    check({tag, ".hit"}, int'(hit), h);
    check({tag, ".miss"}, int'(miss), m);
    check({tag, ".perf"}, int'(perf), p);
    check({tag, ".open"}, int'(open), o);
  endtask
  task automatic count(input int n, output int h, output int m, output int m0);
    h = 0; m = 0; m0 = 0;
    for (int i = 0; i < n; i++) begin
      clk1();
      h += int'(hit);
      m += int'(miss);
      m0 += int'(miss0);
    end
  endtask
  task automatic release_btn();
    btn = 1'b0;
    idle(4);
  endtask
  initial begin
    int h, m, m0;
    #1;
    outs("rst_async", 0, 0, 0, 0);
    idle(2);
    outs("rst", 0, 0, 0, 0);
    rst = 1'b0;
    idle(2);
    outs("idle", 0, 0, 0, 0);
    pulse_note();
    check("t1.open_after_note", int'(open), 1);
    ticks(8);
    btn = 1'b1;
    idle(2);
    outs("t1.pre", 0, 0, 0, 1);
    clk1();
    outs("t1.hit", 1, 0, 1, 0);
    clk1();
    outs("t1.after", 0, 0, 0, 0);
    release_btn();
    pulse_note();
    ticks(3);
    btn = 1'b1;
    idle(3);
    outs("t2.early", 1, 0, 0, 0);
    release_btn();
    pulse_note();
    ticks(16);
    outs("t3.cnt16", 0, 0, 0, 1);
    ticks(1);
    outs("t3.expire", 0, 1, 0, 0);
    clk1();
    outs("t3.after", 0, 0, 0, 0);
    btn = 1'b1;
    count(6, h, m, m0);
    check("t4.stray_miss", m, 1);
    check("t4.stray_hit", h, 0);
    check("t4.nostray", m0, 0);
    release_btn();
    pulse_note();
    ticks(4);
    pulse_note();
    outs("t5.renote", 0, 1, 0, 1);
    clk1();
    outs("t5.after", 0, 0, 0, 1);
    ticks(8);
    btn = 1'b1;
    idle(3);
    outs("t5.hit", 1, 0, 1, 0);
    release_btn();
    pulse_note();
    ticks(16);
    btn = 1'b1;
    idle(2);
    tick = 1'b1;
    clk1();
    tick = 1'b0;
    outs("t6.press_vs_expiry", 1, 0, 0, 0);
    clk1();
    check("t6.no_late_miss", int'(miss), 0);
    release_btn();
    pulse_note();
    ticks(5);
    rst = 1'b1;
    #1;
    outs("t6.rst_mid", 0, 0, 0, 0);
    idle(1);
    rst = 1'b0;
    count(5, h, m, m0);
    check("t6.rst_no_miss", m, 0);
    check("t6.rst_open", int'(open), 0);
    btn = 1'b1;
    count(100, h, m, m0);
    check("t6.held_miss", m, 1);
    check("t6.held_hit", h, 0);
    release_btn();
    en = 1'b0;
    pulse_note();
    check("en.note_ignored", int'(open), 0);
    btn = 1'b1;
    count(4, h, m, m0);
    check("en.press_dropped", m, 0);
    en = 1'b1;
    count(5, h, m, m0);
    check("en.edge_discarded", m + h, 0);
    release_btn();
    pulse_note();
    en = 1'b0;
    clk1();
    check("en.force_idle", int'(open), 0);
    en = 1'b1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
